// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - display constants shared by the sprite blocks and the BRAM arbiter
package display_pkg;

    localparam int SPR_ADR_WIDTH   = 18;
    localparam int SPR_NUM_REQ     = 4;
    localparam int SPR_RD_LATENCY  = 2;
    localparam int SPR_MAX_WAIT    = 15;
    localparam int SPR_SHEET_WIDTH = 512;

    // Wait counters are sized for the largest allowed MAX_WAIT (255).
    localparam int WAIT_W = 8;

endpackage

// File: rtl/sprite_bram_arbiter_if.sv
// rtl/sprite_bram_arbiter_if.sv - requester/BRAM bundle between sprite engines and the arbiter
interface sprite_bram_arbiter_if
    import display_pkg::*;
#(
    parameter int NUM_REQ   = SPR_NUM_REQ,
    parameter int ADR_WIDTH = SPR_ADR_WIDTH
) ();

    logic                           frame_start;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*ADR_WIDTH-1:0]   req_adr;
    logic [NUM_REQ-1:0]             grant;
    logic [ADR_WIDTH-1:0]           bram_adr;
    logic                           bram_dout;
    logic [NUM_REQ-1:0]             rd_valid;
    logic [NUM_REQ-1:0]             rd_data;
    logic [NUM_REQ-1:0]             starve;

    modport slave (
        input  frame_start, req, req_adr, bram_dout,
        output grant, bram_adr, rd_valid, rd_data, starve
    );

    modport master (
        output frame_start, req, req_adr, bram_dout,
        input  grant, bram_adr, rd_valid, rd_data, starve
    );

endinterface

// File: rtl/sprite_bram_arbiter_rr_pick.sv
// rtl/sprite_bram_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   win_idx,
    output logic               any_valid
);

    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        winner    = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        // Walk ptr, ptr+1, ... wrapping at NUM_REQ; the first eligible index wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = cand_sum[PTR_W-1:0];
            if (!any_valid && eligible[cand]) begin
                any_valid     = 1'b1;
                winner[cand]  = 1'b1;
                win_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_bram_arbiter.sv
// rtl/sprite_bram_arbiter.sv - round-robin arbiter sharing one sprite BRAM read port among requesters
module sprite_bram_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ    = SPR_NUM_REQ,
    parameter int ADR_WIDTH  = SPR_ADR_WIDTH,
    parameter int RD_LATENCY = SPR_RD_LATENCY,
    parameter int MAX_WAIT   = SPR_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_bram_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   grant_q;
    logic [ADR_WIDTH-1:0] adr_q;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_any;
    logic [ADR_WIDTH-1:0] win_adr;

    logic [NUM_REQ-1:0]   tag_q [RD_LATENCY];
    logic [NUM_REQ-1:0]   rd_hold_q;
    logic [NUM_REQ-1:0]   rd_data_c;

    logic [WAIT_W-1:0]    wait_cnt [NUM_REQ];
    logic [WAIT_W-1:0]    wait_nxt [NUM_REQ];
    logic [NUM_REQ-1:0]   starve_set;
    logic [NUM_REQ-1:0]   starve_q;

    // A requester being granted this cycle sits out, so a held req wins at most every other cycle.
    assign eligible = bus.req & ~grant_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eligible  (eligible),
        .ptr       (ptr),
        .winner    (win_oh),
        .win_idx   (win_idx),
        .any_valid (win_any)
    );

    always_comb begin
        win_adr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_adr = bus.req_adr[i*ADR_WIDTH +: ADR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            adr_q   <= '0;
            ptr     <= '0;
        end else begin
            grant_q <= win_oh;
            adr_q   <= win_adr;
            if (bus.frame_start) begin
                ptr <= '0;
            end else if (win_any) begin
                ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // Stage 0 follows the grant cycle; the last stage lines up with bram_dout for that address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            rd_hold_q <= '0;
        end else begin
            tag_q[0] <= grant_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            rd_hold_q <= rd_data_c;
        end
    end

    assign rd_data_c = (tag_q[RD_LATENCY-1] & {NUM_REQ{bus.bram_dout}}) |
                       (~tag_q[RD_LATENCY-1] & rd_hold_q);

    // A winning requester is served, so its counter holds rather than counting that cycle.
    always_comb begin
        starve_set = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_nxt[i] = wait_cnt[i];
            if (!bus.req[i] || grant_q[i]) begin
                wait_nxt[i] = '0;
            end else if (!win_oh[i] && (wait_cnt[i] != WAIT_W'(MAX_WAIT))) begin
                wait_nxt[i] = wait_cnt[i] + 1'b1;
            end
            starve_set[i] = (wait_nxt[i] == WAIT_W'(MAX_WAIT));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= wait_nxt[i];
            end
            starve_q <= bus.frame_start ? '0 : (starve_q | starve_set);
        end
    end

    assign bus.grant    = grant_q;
    assign bus.bram_adr = adr_q;
    assign bus.rd_valid = tag_q[RD_LATENCY-1];
    assign bus.rd_data  = rd_data_c;
    assign bus.starve   = starve_q;

endmodule

// File: tb/tb_sprite_bram_arbiter.sv
// tb/tb_sprite_bram_arbiter.sv - directed self-checking bench for sprite_bram_arbiter
module tb_sprite_bram_arbiter;
    import display_pkg::*;

    localparam int NR  = 4;
    localparam int AW  = 18;
    localparam int LAT = 2;
    localparam int MW  = 3;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [AW-1:0] adr_d1 = '0;
    logic [AW-1:0] adr_d2 = '0;
    logic [AW-1:0] adr_tab [NR];
    logic [NR-1:0] grant_tab [8];
    logic [NR-1:0] exp_hold;
    int            n_tests = 0;
    int            n_fail  = 0;

    sprite_bram_arbiter_if #(.NUM_REQ(NR), .ADR_WIDTH(AW)) bus ();

    sprite_bram_arbiter #(
        .NUM_REQ    (NR),
        .ADR_WIDTH  (AW),
        .RD_LATENCY (LAT),
        .MAX_WAIT   (MW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: data bit is address bit 0, returned LAT cycles after bram_adr.
    always @(posedge clk) begin
        adr_d1 <= bus.bram_adr;
        adr_d2 <= adr_d1;
    end
    assign bus.bram_dout = adr_d2[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] adr_of(input logic [NR-1:0] oh);
        adr_of = '0;
        for (int i = 0; i < NR; i++) begin
            if (oh[i]) adr_of = adr_tab[i];
        end
    endfunction

    initial begin
        adr_tab[0] = 18'h00A01;
        adr_tab[1] = 18'(3 * SPR_SHEET_WIDTH + 2);
        adr_tab[2] = 18'h00123;
        adr_tab[3] = 18'h3FFFE;
        grant_tab  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        bus.frame_start = 1'b0;
        bus.req         = '0;
        bus.req_adr     = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};

        tick();
        tick();
        check("rst_grant",    32'(bus.grant),    32'h0);
        check("rst_bram_adr", 32'(bus.bram_adr), 32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_rd_data",  32'(bus.rd_data),  32'h0);
        check("rst_starve",   32'(bus.starve),   32'h0);
        reset = 1'b0;

        // Single request from requester 2.
        bus.req = 4'b0100;
        tick();
        check("single_grant",    32'(bus.grant),    32'h4);
        check("single_bram_adr", 32'(bus.bram_adr), 32'h00123);
        bus.req = '0;
        tick();
        check("single_rv_early", 32'(bus.rd_valid), 32'h0);
        tick();
        check("single_rv",       32'(bus.rd_valid), 32'h4);
        check("single_rd_data",  32'(bus.rd_data),  32'h4);
        tick();
        check("single_rv_gone",  32'(bus.rd_valid), 32'h0);
        check("single_rd_hold",  32'(bus.rd_data),  32'h4);

        // All four held from ptr=0: grants 0,1,2,3,0 and matching returns.
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        exp_hold = 4'b0100;
        bus.req = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) bus.req = '0;
            check($sformatf("rr_grant_c%0d", k), 32'(bus.grant), 32'(grant_tab[k]));
            check($sformatf("rr_adr_c%0d", k), 32'(bus.bram_adr), 32'(adr_of(grant_tab[k])));
            if (k >= 2) begin
                check($sformatf("rr_rv_c%0d", k), 32'(bus.rd_valid), 32'(grant_tab[k-2]));
                for (int i = 0; i < NR; i++) begin
                    if (grant_tab[k-2][i]) exp_hold[i] = adr_tab[i][0];
                end
                check($sformatf("rr_rd_data_c%0d", k), 32'(bus.rd_data), 32'(exp_hold));
            end
        end
        check("rr_starve3", 32'(bus.starve), 32'h8);

        // Starvation of requester 3 after three waiting cycles, cleared by frame_start.
        bus.frame_start = 1'b1;
        tick();
        check("starve_clr_fs", 32'(bus.starve), 32'h0);
        bus.frame_start = 1'b0;
        bus.req = 4'b1111;
        tick();
        check("starve_d1", 32'(bus.starve), 32'h0);
        check("starve_g1", 32'(bus.grant),  32'h1);
        tick();
        check("starve_d2", 32'(bus.starve), 32'h0);
        tick();
        bus.req = '0;
        bus.frame_start = 1'b1;
        check("starve_set", 32'(bus.starve), 32'h8);
        tick();
        check("starve_cleared", 32'(bus.starve), 32'h0);
        bus.frame_start = 1'b0;
        bus.req = 4'b1010;
        tick();
        check("fs_ptr0_grant", 32'(bus.grant), 32'h2);
        bus.req = '0;
        tick();
        tick();
        tick();

        // frame_start coincident with a grant to requester 1.
        bus.req_adr[1*AW +: AW] = 18'h2A5A5;
        bus.req = 4'b0010;
        bus.frame_start = 1'b1;
        tick();
        check("fsg_grant",    32'(bus.grant),    32'h2);
        check("fsg_bram_adr", 32'(bus.bram_adr), 32'h2A5A5);
        bus.req = 4'b1001;
        bus.frame_start = 1'b0;
        tick();
        check("fsg_ptr0", 32'(bus.grant), 32'h1);
        bus.req = '0;
        tick();
        check("fsg_rv1",  32'(bus.rd_valid),   32'h2);
        check("fsg_rd1",  32'(bus.rd_data[1]), 32'h1);
        tick();
        check("fsg_rv0",  32'(bus.rd_valid),   32'h1);
        check("fsg_hold", 32'(bus.rd_data[1]), 32'h1);

        // Reset with two reads in flight.
        bus.req = 4'b1111;
        tick();
        check("inflight_g1", 32'(bus.grant), 32'h2);
        tick();
        check("inflight_g2", 32'(bus.grant), 32'h4);
        bus.req = '0;
        reset = 1'b1;
        #1;
        check("mid_rst_grant",    32'(bus.grant),    32'h0);
        check("mid_rst_bram_adr", 32'(bus.bram_adr), 32'h0);
        check("mid_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("mid_rst_rd_data",  32'(bus.rd_data),  32'h0);
        check("mid_rst_starve",   32'(bus.starve),   32'h0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst_rv%0d", k), 32'(bus.rd_valid), 32'h0);
            check($sformatf("post_rst_rd%0d", k), 32'(bus.rd_data),  32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_bram_arbiter.md
SPRITE_BRAM_ARBITER -- requirements
Module: sprite_bram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sprite requesters sharing one sprite BRAM read port.
REQ-002 Parameter ADR_WIDTH, default 18: BRAM address width.
REQ-003 Parameter RD_LATENCY, default 2: cycles from bram_adr registered to bram_dout valid, range 1..4.
REQ-004 Parameter MAX_WAIT, default 15: wait cycles after which a requester is flagged starved, range 1..255.
REQ-005 clk  input  1  pixel clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 frame_start  input  1  one-cycle pulse at start of frame.
REQ-008 req  input  NUM_REQ  per-requester read request, level.
REQ-009 req_adr  input  NUM_REQ*ADR_WIDTH  packed request addresses; slice i belongs to requester i.
REQ-010 grant  output  NUM_REQ  registered one-hot grant, at most one bit high.
REQ-011 bram_adr  output  ADR_WIDTH  registered BRAM read address.
REQ-012 bram_dout  input  1  BRAM read data (sprite pixel bit).
REQ-013 rd_valid  output  NUM_REQ  one-hot, one-cycle pulse marking returned data for requester i.
REQ-014 rd_data  output  NUM_REQ  returned pixel bit, per requester, held until that requester's next rd_valid.
REQ-015 starve  output  NUM_REQ  sticky starvation flags.

Function
REQ-016 Arbitration evaluated every cycle over eligible requests: req[i] high and grant[i] low in same cycle.
REQ-017 Round-robin: search starts at pointer ptr, ascending index, wrapping NUM_REQ-1 to 0; first eligible wins.
REQ-018 Request eligible in cycle N: grant[winner] high and bram_adr = req_adr[winner] in cycle N+1.
REQ-019 After grant to i, ptr = (i+1) mod NUM_REQ; no grant leaves ptr unchanged.
REQ-020 No eligible request: grant all-zero and bram_adr = 0 next cycle.
REQ-021 Requester holding req continuously is granted at most every other cycle; other eligible requesters win in the gap per REQ-017.
REQ-022 Requester shall hold req_adr stable until grant seen; arbiter samples req_adr only in winning cycle.
REQ-023 Grant in cycle G: rd_valid[i] high and rd_data[i] = bram_dout in cycle G+RD_LATENCY; tag pipeline of RD_LATENCY stages carries valid and requester index.
REQ-024 Pipeline accepts one new read per cycle; up to RD_LATENCY reads in flight, no stalls.
REQ-025 Per-requester wait counter: increments while req[i] high and not granted, saturates at MAX_WAIT, clears on grant[i] or req[i] low.
REQ-026 starve[i] set when wait counter reaches MAX_WAIT; cleared only by frame_start or reset.
REQ-027 frame_start: ptr = 0 and all starve cleared; overrides simultaneous ptr update and starve set; does not cancel grants or in-flight reads.

Reset
REQ-028 Reset asserted: grant = 0, bram_adr = 0, rd_valid = 0, rd_data = 0, starve = 0, ptr = 0, wait counters = 0, tag pipeline emptied.
REQ-029 Reset mid-read: in-flight reads discarded; no rd_valid for them after reset release.
REQ-030 First grant possible in cycle after first rising edge with reset low.

Structure
REQ-031 Shared package display_pkg holds ADR_WIDTH, default NUM_REQ, RD_LATENCY, MAX_WAIT and sprite sheet width constant shared with sprite blocks.
REQ-032 One sub-module rr_pick: combinational round-robin selector (eligible vector, ptr) -> one-hot winner, index, any-valid.
REQ-033 Tag pipeline, wait counters, starve flags stay in top module.

Verification
REQ-034 Single req[2] pulse, req_adr[2]=0x00123, RD_LATENCY=2 -> grant=0100 and bram_adr=0x00123 next cycle; rd_valid[2] two cycles later with rd_data[2]=bram_dout.
REQ-035 req=1111 held, ptr=0 -> grant order 0,1,2,3,0; no requester granted twice consecutively; rd_valid order matches.
REQ-036 req[3] held while req[0..2] alternately win, MAX_WAIT=3 -> starve[3]=1 after 3 waiting cycles; frame_start -> starve=0, ptr=0.
REQ-037 Reset asserted with 2 reads in flight -> all outputs 0 immediately; no rd_valid after release.
REQ-038 frame_start coincident with grant to 1 -> ptr=0 next cycle, grant and returned data for 1 unaffected.
